// File: rtl/vector_mac_pkg.sv
`default_nettype none
// vector_mac_pkg: sequencer states and saturating add for vector_mac_engine (rev 1.0).
package vector_mac_pkg;

  localparam int MAXW = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Unsigned add clamped to 2^w-1; operands arrive zero-extended to MAXW.
  function automatic logic [MAXW-1:0] sat_add(input logic [MAXW-1:0] a,
                                              input logic [MAXW-1:0] b,
                                              input int              w);
    logic [MAXW:0]   sum;
    logic [MAXW-1:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (w >= MAXW) ? '1 : ((MAXW'(1) << w) - MAXW'(1));
    sat_add = (sum > {1'b0, lim}) ? lim : sum[MAXW-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/vector_mac_engine_mac_unit.sv
`default_nettype none
// mac_unit: combinational unsigned multiply-accumulate; clamps under SATURATE_EN, wraps otherwise (rev 1.0).
module mac_unit
  import vector_mac_pkg::*;
#(
  parameter int DW   = 32,
  parameter int ACCW = 64
) (
  input  logic [DW-1:0]   a_i,
  input  logic [DW-1:0]   b_i,
  input  logic [ACCW-1:0] acc_i,
  output logic [ACCW-1:0] acc_o,
  output logic            ovf_o
);

  localparam int PW = 2 * DW;

  logic [PW-1:0] prod;
  assign prod = {{DW{1'b0}}, a_i} * {{DW{1'b0}}, b_i};

`ifdef SATURATE_EN
  localparam int SW = (PW > ACCW) ? PW : ACCW;

  // Exact sum is wide enough to hold any product plus the accumulator.
  logic [SW:0] sum;
  assign sum   = (SW+1)'(acc_i) + (SW+1)'(prod);
  assign ovf_o = |(sum >> ACCW);
  assign acc_o = ACCW'(sat_add(MAXW'(acc_i), MAXW'(prod), ACCW));
`else
  assign acc_o = acc_i + ACCW'(prod);
  assign ovf_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/vector_mac_engine.sv
`default_nettype none
// vector_mac_engine: N-element dot-product lane with START/BUSY/DONE sequencer.
// Optional SATURATE_EN macro clamps the accumulator and raises sticky OVF (rev 1.0).
module vector_mac_engine
  import vector_mac_pkg::*;
#(
  parameter  int N    = 16,
  parameter  int DW   = 32,
  parameter  int ACCW = 64,
  localparam int LW   = $clog2(N + 1),
  localparam int PCW  = $clog2(N)
) (
  input  logic            CLK,
  input  logic            RSTN,
  input  logic [N*DW-1:0] DATAIN,
  input  logic            WRITE_MAT,
  input  logic            MAT_MUX,
  input  logic            START,
  input  logic [LW-1:0]   LEN,
  input  logic            ACC_CLR,
  output logic            BUSY,
  output logic            DONE,
  output logic [PCW-1:0]  PC_Counter,
  output logic [ACCW-1:0] DATAOUT,
  output logic            OVF
);

  state_t          state_q, state_d;
  logic [DW-1:0]   bank_a_q [N];
  logic [DW-1:0]   bank_a_d [N];
  logic [DW-1:0]   bank_b_q [N];
  logic [DW-1:0]   bank_b_d [N];
  logic [ACCW-1:0] acc_q, acc_d;
  logic [PCW-1:0]  pc_q, pc_d;
  logic [LW-1:0]   len_q, len_d;
  logic            ovf_q, ovf_d;

  logic [ACCW-1:0] mac_acc;
  logic            mac_ovf;
  logic [LW-1:0]   len_clamped;
  logic            last_elem;

  mac_unit #(
    .DW   (DW),
    .ACCW (ACCW)
  ) u_mac (
    .a_i   (bank_a_q[pc_q]),
    .b_i   (bank_b_q[pc_q]),
    .acc_i (acc_q),
    .acc_o (mac_acc),
    .ovf_o (mac_ovf)
  );

  assign len_clamped = (LEN > LW'(N)) ? LW'(N) : LEN;
  assign last_elem   = (LW'(pc_q) + LW'(1)) == len_q;

  always_comb begin
    state_d  = state_q;
    bank_a_d = bank_a_q;
    bank_b_d = bank_b_q;
    acc_d    = acc_q;
    pc_d     = pc_q;
    len_d    = len_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: begin
        // Banks are only writable here, so a run always sees stable operands.
        if (WRITE_MAT) begin
          for (int i = 0; i < N; i++) begin
            if (MAT_MUX) bank_b_d[i] = DATAIN[i*DW +: DW];
            else         bank_a_d[i] = DATAIN[i*DW +: DW];
          end
        end
        if (START) begin
          len_d = len_clamped;
          pc_d  = '0;
          if (ACC_CLR) begin
            acc_d = '0;
            ovf_d = 1'b0;
          end
          state_d = (len_clamped == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        acc_d = mac_acc;
        ovf_d = ovf_q | mac_ovf;
        if (last_elem) begin
          pc_d    = '0;
          state_d = FIN;
        end else begin
          pc_d = pc_q + PCW'(1);
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RSTN) begin
    if (RSTN) begin
      state_q <= IDLE;
      for (int i = 0; i < N; i++) begin
        bank_a_q[i] <= '0;
        bank_b_q[i] <= '0;
      end
      acc_q <= '0;
      pc_q  <= '0;
      len_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bank_a_q <= bank_a_d;
      bank_b_q <= bank_b_d;
      acc_q    <= acc_d;
      pc_q     <= pc_d;
      len_q    <= len_d;
      ovf_q    <= ovf_d;
    end
  end

  assign BUSY       = (state_q == RUN);
  assign DONE       = (state_q == FIN);
  assign PC_Counter = pc_q;
  assign DATAOUT    = acc_q;
  assign OVF        = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_vector_mac_engine.sv
`default_nettype none
// tb_vector_mac_engine: randomized and directed runs scored against a dot-product reference model.
module tb_vector_mac_engine;

  localparam int N    = 16;
  localparam int DW   = 32;
  localparam int ACCW = 64;
  localparam int LW   = $clog2(N + 1);
  localparam int PCW  = $clog2(N);

  logic            CLK;
  logic            RSTN;
  logic [N*DW-1:0] DATAIN;
  logic            WRITE_MAT;
  logic            MAT_MUX;
  logic            START;
  logic [LW-1:0]   LEN;
  logic            ACC_CLR;
  logic            BUSY;
  logic            DONE;
  logic [PCW-1:0]  PC_Counter;
  logic [ACCW-1:0] DATAOUT;
  logic            OVF;

  vector_mac_engine #(.N(N), .DW(DW), .ACCW(ACCW)) dut (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .DATAIN     (DATAIN),
    .WRITE_MAT  (WRITE_MAT),
    .MAT_MUX    (MAT_MUX),
    .START      (START),
    .LEN        (LEN),
    .ACC_CLR    (ACC_CLR),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .PC_Counter (PC_Counter),
    .DATAOUT    (DATAOUT),
    .OVF        (OVF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [ACCW-1:0] acc;
    logic            ovf;
    int unsigned     done_neg;
  } exp_t;

  exp_t            sbq[$];
  logic [DW-1:0]   ma [N];
  logic [DW-1:0]   mb [N];
  logic [ACCW-1:0] macc;
  logic            movf;
  int unsigned     negcnt = 0;
  int unsigned     dones  = 0;
  int              checks = 0;
  int              errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every DONE pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    exp_t e;
    negcnt++;
    if (!RSTN && DONE) begin
      dones++;
      if (sbq.size() == 0) begin
        chk("unexpected_done", 128'(DONE), 128'(0));
      end else begin
        e = sbq.pop_front();
        chk("done_data", 128'(DATAOUT), 128'(e.acc));
        chk("done_ovf", 128'(OVF), 128'(e.ovf));
        chk("done_pc", 128'(PC_Counter), 128'(0));
        chk("done_latency", 128'(negcnt), 128'(e.done_neg));
      end
    end
  end

  function automatic logic [N*DW-1:0] mk_seq();
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(N - i);
    return v;
  endfunction

  function automatic logic [N*DW-1:0] mk_rand();
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  function automatic void model_write(input bit sel, input logic [N*DW-1:0] v);
    for (int i = 0; i < N; i++) begin
      if (sel) mb[i] = v[i*DW +: DW];
      else     ma[i] = v[i*DW +: DW];
    end
  endfunction

  task automatic load(input bit sel, input logic [N*DW-1:0] v);
    @(posedge CLK); #1;
    DATAIN = v; MAT_MUX = sel; WRITE_MAT = 1'b1;
    @(posedge CLK); #1;
    WRITE_MAT = 1'b0;
    model_write(sel, v);
  endtask

  task automatic run(input int len, input bit clr, input bit disturb,
                     input bit wr = 1'b0, input bit wsel = 1'b0,
                     input logic [N*DW-1:0] wv = '0);
    int unsigned     d0;
    int              lc;
    logic [127:0]    tot;
    logic [ACCW-1:0] maxv;
    exp_t            e;
    bit              seen;
    @(posedge CLK); #1;
    START = 1'b1; LEN = LW'(len); ACC_CLR = clr;
    if (wr) begin
      DATAIN = wv; MAT_MUX = wsel; WRITE_MAT = 1'b1;
    end
    @(posedge CLK);
    d0 = dones;
    if (wr) model_write(wsel, wv);
    lc = (len > N) ? N : len;
    if (clr) begin
      macc = '0;
      movf = 1'b0;
    end
    tot = 128'(macc);
    for (int i = 0; i < lc; i++) tot += 128'(ma[i]) * 128'(mb[i]);
    maxv = '1;
`ifdef SATURATE_EN
    if (tot > 128'(maxv)) begin
      macc = maxv;
      movf = 1'b1;
    end else begin
      macc = ACCW'(tot);
    end
`else
    macc = ACCW'(tot);
`endif
    e.acc = macc; e.ovf = movf; e.done_neg = negcnt + 32'(lc) + 1;
    sbq.push_back(e);
    #1;
    START = 1'b0; WRITE_MAT = 1'b0;
    @(negedge CLK); #1;
    chk("busy", 128'(BUSY), 128'(lc != 0));
    if (disturb) begin
      repeat (3) @(posedge CLK);
      #1;
      DATAIN = '0; MAT_MUX = 1'b0; WRITE_MAT = 1'b1;
      START = 1'b1; LEN = LW'(5); ACC_CLR = 1'b1;
      @(posedge CLK); #1;
      WRITE_MAT = 1'b0; START = 1'b0;
    end
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      if (dones > d0) seen = 1'b1;
      else begin
        @(negedge CLK); #1;
      end
    end
    chk("done_timeout", 128'(seen), 128'(1));
  endtask

  task automatic reset_mid_run();
    bit hit;
    @(posedge CLK); #1;
    START = 1'b1; LEN = LW'(16); ACC_CLR = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 30 && !hit; k++) begin
      @(negedge CLK);
      if (PC_Counter == PCW'(7)) hit = 1'b1;
    end
    chk("reach_pc7", 128'(hit), 128'(1));
    RSTN = 1'b1;
    #1;
    chk("rst_dataout", 128'(DATAOUT), 128'(0));
    chk("rst_pc", 128'(PC_Counter), 128'(0));
    chk("rst_busy", 128'(BUSY), 128'(0));
    chk("rst_done", 128'(DONE), 128'(0));
    chk("rst_ovf", 128'(OVF), 128'(0));
    for (int i = 0; i < N; i++) begin
      ma[i] = '0;
      mb[i] = '0;
    end
    macc = '0;
    movf = 1'b0;
    @(posedge CLK); #1;
    RSTN = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N*DW-1:0] ones;
    ones = '1;
    RSTN = 1'b1; DATAIN = '0; WRITE_MAT = 1'b0; MAT_MUX = 1'b0;
    START = 1'b0; LEN = '0; ACC_CLR = 1'b0;
    for (int i = 0; i < N; i++) begin
      ma[i] = '0;
      mb[i] = '0;
    end
    macc = '0;
    movf = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_dataout", 128'(DATAOUT), 128'(0));
    chk("reset_pc", 128'(PC_Counter), 128'(0));
    chk("reset_busy", 128'(BUSY), 128'(0));
    chk("reset_done", 128'(DONE), 128'(0));
    chk("reset_ovf", 128'(OVF), 128'(0));
    RSTN = 1'b0;

    load(1'b0, mk_seq());
    load(1'b1, mk_seq());
    run(16, 1'b1, 1'b0);
    chk("dot16", 128'(DATAOUT), 128'(1496));
    run(4, 1'b1, 1'b0);
    chk("dot4", 128'(DATAOUT), 128'(846));
    run(16, 1'b0, 1'b0);
    chk("accum", 128'(DATAOUT), 128'(2342));
    run(0, 1'b1, 1'b0);
    chk("len0_clear", 128'(DATAOUT), 128'(0));
    run(20, 1'b1, 1'b0);
    chk("len_clamp", 128'(DATAOUT), 128'(1496));
    run(16, 1'b1, 1'b1);
    chk("busy_ignore", 128'(DATAOUT), 128'(1496));
    repeat (4) @(posedge CLK);
    run(4, 1'b1, 1'b0, 1'b1, 1'b0, '0);
    chk("write_with_start", 128'(DATAOUT), 128'(0));

    load(1'b0, ones);
    load(1'b1, ones);
    run(2, 1'b1, 1'b0);
    run(16, 1'b0, 1'b0);

    for (int it = 0; it < 20; it++) begin
      if ($urandom_range(0, 1) == 1) load(1'b0, mk_rand());
      if ($urandom_range(0, 1) == 1) load(1'b1, mk_rand());
      run(int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)), 1'b0);
    end

    reset_mid_run();
    run(16, 1'b0, 1'b0);
    chk("post_reset_run", 128'(DATAOUT), 128'(0));

    repeat (3) @(posedge CLK);
    chk("queue_drained", 128'(sbq.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
